cmp_seq_scheduler: RTL

- Time-multiplexes one shared unsigned less-than comparator across NUM_PAIRS operand pairs.
- Accepts a packed batch of x/y operands over a valid/ready handshake and compares one pair per cycle.
- Assembles the per-pair result bits into one vector and returns it over a second valid/ready handshake.
- Sits between the operand source (feature/threshold buffers) and the consumer of the packed binary result vector.

---
 rtl/cmp_seq_scheduler.sv | 93 +++++++++
 1 files changed

// File: rtl/cmp_seq_scheduler.sv
// rtl/cmp_seq_scheduler.sv - one shared less-than comparator time-multiplexed over NUM_PAIRS operand pairs
// Optional build macro CMP_SIGNED_EN selects a signed comparison instead of unsigned.
module cmp_seq_scheduler #(
  parameter int NUM_PAIRS = 8,
  parameter int DATA_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_PAIRS*DATA_W-1:0] x_bus,
  input  logic [NUM_PAIRS*DATA_W-1:0] y_bus,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_PAIRS-1:0]        result,
  output logic                        busy
);

  localparam int CNT_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam int BUS_W = NUM_PAIRS * DATA_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [BUS_W-1:0]     x_reg;
  logic [BUS_W-1:0]     y_reg;
  logic [NUM_PAIRS-1:0] res_reg;
  logic [NUM_PAIRS-1:0] pos_mask;
  logic [DATA_W-1:0]    x_cur;
  logic [DATA_W-1:0]    y_cur;
  logic                 lt;
  logic                 last;

  // Operand registers shift left each compare, so the current pair is always on top.
  assign x_cur    = x_reg[BUS_W-1 -: DATA_W];
  assign y_cur    = y_reg[BUS_W-1 -: DATA_W];
  assign pos_mask = {1'b1, {(NUM_PAIRS-1){1'b0}}} >> cnt;
  assign last     = (cnt == CNT_W'(NUM_PAIRS - 1));

`ifdef CMP_SIGNED_EN
  assign lt = $signed(x_cur) < $signed(y_cur);
`else
  assign lt = x_cur < y_cur;
`endif

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_RUN) || (state == S_DONE);
  assign result    = res_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      x_reg   <= '0;
      y_reg   <= '0;
      res_reg <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            x_reg <= x_bus;
            y_reg <= y_bus;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          x_reg <= x_reg << DATA_W;
          y_reg <= y_reg << DATA_W;
          // The previous result stays visible until this first compare clears it.
          if (cnt == '0)
            res_reg <= lt ? pos_mask : '0;
          else
            res_reg <= lt ? (res_reg | pos_mask) : (res_reg & ~pos_mask);
          if (last)
            state <= S_DONE;
          else
            cnt <= cnt + CNT_W'(1);
        end
        S_DONE: begin
          if (out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
